alu_system_sequencer: RTL

- Hardwired control unit that sequences the ALU system datapath: register file, ALU, address register file, memory, IR, DR and muxes.
- Fetches a 16-bit instruction in two byte cycles, then decodes and executes a small instruction set by driving every datapath control line.
- Sits beside the datapath at the system level.
- Only feedback from the datapath: IROut and FlagsOut.

---
 rtl/alu_sys_ctrl_pkg.sv | 72 +++++++
 rtl/alu_system_sequencer_seq_decoder.sv | 90 +++++++++
 rtl/alu_system_sequencer.sv | 60 ++++++
 3 files changed

// File: rtl/alu_sys_ctrl_pkg.sv
// alu_sys_ctrl_pkg: sequencer states, opcodes, datapath control encodings and the control bundle; STEP_WAIT exists only with SEQ_SINGLE_STEP_EN
package alu_sys_ctrl_pkg;
  typedef enum logic [2:0] {
    S_FETCH_L,
    S_FETCH_H,
    S_EXEC,
    S_WB,
    S_HALT
`ifdef SEQ_SINGLE_STEP_EN
    , S_STEP_WAIT
`endif
  } state_t;
`ifdef SEQ_SINGLE_STEP_EN
  localparam state_t S_DONE_NEXT = S_STEP_WAIT;
`else
  localparam state_t S_DONE_NEXT = S_FETCH_L;
`endif
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR = 4'h4;
  localparam logic [3:0] OP_LDB = 4'h5;
  localparam logic [3:0] OP_STB = 4'h6;
  localparam logic [3:0] OP_BRZ = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [2:0] RF_FUN_LOAD = 3'b010;
  localparam logic [1:0] ARF_FUN_INC = 2'b01;
  localparam logic [1:0] ARF_FUN_LOAD = 2'b10;
  localparam logic [1:0] ARF_FUN_CLEAR = 2'b11;
  localparam logic [1:0] DR_FUN_LOAD_LSB = 2'b01;
  localparam logic [4:0] ALU_PASS_A = 5'b10000;
  localparam logic [4:0] ALU_ADD = 5'b10100;
  localparam logic [4:0] ALU_SUB = 5'b10110;
  localparam logic [4:0] ALU_AND = 5'b10111;
  localparam logic [4:0] ALU_OR = 5'b11000;
  localparam logic [2:0] ARF_SEL_PC = 3'b100;
  localparam logic [2:0] ARF_SEL_AR = 3'b010;
  localparam logic [2:0] ARF_SEL_SP = 3'b001;
  localparam logic [1:0] ARF_OUT_PC = 2'b00;
  localparam logic [1:0] ARF_OUT_SP = 2'b01;
  localparam logic [1:0] ARF_OUT_AR = 2'b10;
  localparam logic [1:0] MUXA_DR = 2'b10;
  typedef struct packed {
    logic [3:0] rf_regsel;
    logic [3:0] rf_scrsel;
    logic [2:0] rf_funsel;
    logic [2:0] rf_outasel;
    logic [2:0] rf_outbsel;
    logic alu_wf;
    logic [4:0] alu_funsel;
    logic [2:0] arf_regsel;
    logic [1:0] arf_funsel;
    logic [1:0] arf_outcsel;
    logic [1:0] arf_outdsel;
    logic dr_e;
    logic [1:0] dr_funsel;
    logic mem_wr;
    logic mem_cs;
    logic ir_lh;
    logic ir_write;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic [1:0] mux_c;
    logic mux_d;
    logic halted;
    logic instr_done;
  } ctl_t;
  function automatic logic [4:0] alu_fun(input logic [3:0] op);
    return op == OP_ADD ? ALU_ADD : op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : ALU_OR;
  endfunction
endpackage

// File: rtl/alu_system_sequencer_seq_decoder.sv
// seq_decoder: combinational (state, IR[15:6], Z) -> control bundle and next state; ports rst, [step], state, ir, z -> ctl, nxt; step only with SEQ_SINGLE_STEP_EN
module seq_decoder
  import alu_sys_ctrl_pkg::*;
(
  input  logic        rst,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  state_t      state,
  input  logic [15:6] ir,
  input  logic        z,
  output ctl_t        ctl,
  output state_t      nxt
);
  logic [3:0] op;
  logic [3:0] rd_sel;
  assign op = ir[15:12];
  assign rd_sel = 4'b1000 >> ir[11:10];
  always_comb begin
    ctl = '0;
    ctl.mem_cs = 1'b1;
    nxt = state;
    if (rst) begin
      ctl.arf_regsel = ARF_SEL_PC;
      ctl.arf_funsel = ARF_FUN_CLEAR;
      nxt = S_FETCH_L;
    end else begin
      case (state)
        S_FETCH_L, S_FETCH_H: begin
          ctl.arf_outdsel = ARF_OUT_PC;
          ctl.mem_cs = 1'b0;
          ctl.ir_lh = state == S_FETCH_H;
          ctl.ir_write = 1'b1;
          ctl.arf_regsel = ARF_SEL_PC;
          ctl.arf_funsel = ARF_FUN_INC;
          nxt = state == S_FETCH_L ? S_FETCH_H : S_EXEC;
        end
        S_EXEC: begin
          ctl.instr_done = 1'b1;
          nxt = S_DONE_NEXT;
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
              ctl.rf_outasel = {1'b0, ir[9:8]};
              ctl.rf_outbsel = {1'b0, ir[7:6]};
              ctl.alu_funsel = alu_fun(op);
              ctl.alu_wf = 1'b1;
              ctl.rf_regsel = rd_sel;
              ctl.rf_funsel = RF_FUN_LOAD;
            end
            OP_LDB: begin
              ctl.arf_outdsel = ARF_OUT_AR;
              ctl.mem_cs = 1'b0;
              ctl.dr_e = 1'b1;
              ctl.dr_funsel = DR_FUN_LOAD_LSB;
              ctl.instr_done = 1'b0;
              nxt = S_WB;
            end
            OP_STB: begin
              ctl.rf_outasel = {1'b0, ir[9:8]};
              ctl.alu_funsel = ALU_PASS_A;
              ctl.arf_outdsel = ARF_OUT_AR;
              ctl.mem_cs = 1'b0;
              ctl.mem_wr = 1'b1;
            end
            OP_BRZ: if (z) begin
              ctl.rf_outasel = {1'b0, ir[9:8]};
              ctl.alu_funsel = ALU_PASS_A;
              ctl.arf_regsel = ARF_SEL_PC;
              ctl.arf_funsel = ARF_FUN_LOAD;
            end
            OP_HALT: nxt = S_HALT;
            default: ;
          endcase
        end
        S_WB: begin
          ctl.mux_a = MUXA_DR;
          ctl.rf_regsel = rd_sel;
          ctl.rf_funsel = RF_FUN_LOAD;
          ctl.instr_done = 1'b1;
          nxt = S_DONE_NEXT;
        end
        S_HALT: ctl.halted = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        S_STEP_WAIT: nxt = step ? S_FETCH_L : S_STEP_WAIT;
`endif
        default: nxt = S_FETCH_L;
      endcase
    end
  end
endmodule

// File: rtl/alu_system_sequencer.sv
// alu_system_sequencer: hardwired two-byte-fetch control unit; in Clock, Reset, [Step], IROut, FlagsOut; out all RF/ALU/ARF/DR/Mem/IR/Mux controls, Halted, InstrDone; SEQ_SINGLE_STEP_EN adds Step and STEP_WAIT
module alu_system_sequencer
  import alu_sys_ctrl_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        Clock,
  input  logic        Reset,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic        Step,
`endif
  input  logic [15:0] IROut,
  input  logic [3:0]  FlagsOut,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [2:0]  RF_FunSel,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic        ALU_WF,
  output logic [4:0]  ALU_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic [1:0]  ARF_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic        DR_E,
  output logic [1:0]  DR_FunSel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic [1:0]  MuxCSel,
  output logic        MuxDSel,
  output logic        Halted,
  output logic        InstrDone
);
  state_t state_q, state_d;
  ctl_t ctl;
  logic unused_ok;
  assign unused_ok = ^{IROut[5:0], FlagsOut[2:0]};
  if (PC_RESET != 16'h0000) begin : g_pc_reset_check
    $error("PC_RESET must be 16'h0000: the PC is reset only through the ARF clear");
  end
  seq_decoder u_dec (
    .rst(Reset),
`ifdef SEQ_SINGLE_STEP_EN
    .step(Step),
`endif
    .state(state_q),
    .ir(IROut[15:6]),
    .z(FlagsOut[3]),
    .ctl(ctl),
    .nxt(state_d)
  );
  always_ff @(posedge Clock) state_q <= Reset ? S_FETCH_L : state_d;
  assign {RF_RegSel, RF_ScrSel, RF_FunSel, RF_OutASel, RF_OutBSel, ALU_WF, ALU_FunSel,
          ARF_RegSel, ARF_FunSel, ARF_OutCSel, ARF_OutDSel, DR_E, DR_FunSel, Mem_WR, Mem_CS,
          IR_LH, IR_Write, MuxASel, MuxBSel, MuxCSel, MuxDSel, Halted, InstrDone} = ctl;
endmodule
